// File: rtl/sh7604_frt_intc_if.sv
// Internal register bus between the CPU side (master) and the FRT interrupt
// controller register block (slave).
interface sh7604_frt_intc_if;
  logic [31:0] IBUS_A;
  logic [31:0] IBUS_DI;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;
  logic        IBUS_ACT;

  modport master (
    output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DO, IBUS_BUSY, IBUS_ACT
  );

  modport slave (
    input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DO, IBUS_BUSY, IBUS_ACT
  );
endinterface

// File: rtl/sh7604_frt_intc.sv
// SH7604 FRT interrupt controller slice: IPRB/VCRC/VCRD registers plus a
// fixed-priority request FSM that latches one winner until ACK or withdrawal.
module sh7604_frt_intc #(
  parameter logic [6:0] VEC_RST = 7'h00
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CE_R,
  input  logic                      CE_F,
  input  logic                      ICI_IRQ,
  input  logic                      OCIA_IRQ,
  input  logic                      OCIB_IRQ,
  input  logic                      OVI_IRQ,
  input  logic [3:0]                IMASK,
  sh7604_frt_intc_if.slave          ibus,
  output logic                      INT_REQ,
  output logic [3:0]                INT_LVL,
  output logic [6:0]                INT_VEC,
  input  logic                      INT_ACK,
  output logic [1:0]                ACK_SRC
);

  localparam logic [29:0] ADDR_IPRB = 30'h3FFF_FF98;
  localparam logic [29:0] ADDR_VCRC = 30'h3FFF_FF99;
  localparam logic [29:0] ADDR_VCRD = 30'h3FFF_FF9A;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_LOCK} state_t;

  state_t      r_state, w_state_nx;
  logic [3:0]  r_pri;
  logic [6:0]  r_ficv, r_focv, r_fovv;
  logic        r_req, w_req_nx;
  logic [3:0]  r_lvl, w_lvl_nx;
  logic [6:0]  r_vec, w_vec_nx;
  logic [1:0]  r_ack_src, w_ack_src_nx;
  logic [1:0]  r_src, w_src_nx;
  logic        r_lock_cnt, w_lock_cnt_nx;
  logic [31:0] r_do;

  logic        w_sel_iprb, w_sel_vcrc, w_sel_vcrd, w_sel_any, w_wr;
  logic [31:0] w_rdata;
  logic [3:0]  w_irq, w_elig;
  logic        w_lvl_ok;
  logic [1:0]  w_win;
  logic [6:0]  w_win_vec;
  logic        w_unused;

  assign w_sel_iprb = (ibus.IBUS_A[31:2] == ADDR_IPRB);
  assign w_sel_vcrc = (ibus.IBUS_A[31:2] == ADDR_VCRC);
  assign w_sel_vcrd = (ibus.IBUS_A[31:2] == ADDR_VCRD);
  assign w_sel_any  = w_sel_iprb | w_sel_vcrc | w_sel_vcrd;
  assign w_wr       = ibus.IBUS_REQ & ibus.IBUS_WE & CE_R;
  assign w_unused   = &{1'b0, ibus.IBUS_A[1:0], ibus.IBUS_DI[31], ibus.IBUS_DI[23:15],
                        ibus.IBUS_DI[7], ibus.IBUS_BA[2]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pri  <= '0;
      r_ficv <= VEC_RST;
      r_focv <= VEC_RST;
      r_fovv <= VEC_RST;
    end else if (w_wr) begin
      if (w_sel_iprb && ibus.IBUS_BA[3]) r_pri  <= ibus.IBUS_DI[27:24];
      if (w_sel_vcrc && ibus.IBUS_BA[1]) r_ficv <= ibus.IBUS_DI[14:8];
      if (w_sel_vcrc && ibus.IBUS_BA[0]) r_focv <= ibus.IBUS_DI[6:0];
      if (w_sel_vcrd && ibus.IBUS_BA[3]) r_fovv <= ibus.IBUS_DI[30:24];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_iprb) w_rdata[27:24] = r_pri;
    if (w_sel_vcrc) begin
      w_rdata[14:8] = r_ficv;
      w_rdata[6:0]  = r_focv;
    end
    if (w_sel_vcrd) w_rdata[30:24] = r_fovv;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       r_do <= '0;
    else if (CE_F) r_do <= (ibus.IBUS_REQ && !ibus.IBUS_WE) ? w_rdata : '0;
  end

  assign ibus.IBUS_DO   = r_do;
  assign ibus.IBUS_ACT  = w_sel_any;
  assign ibus.IBUS_BUSY = 1'b0;

  assign w_irq    = {OVI_IRQ, OCIB_IRQ, OCIA_IRQ, ICI_IRQ};
  assign w_lvl_ok = (r_pri != 4'd0) && (r_pri > IMASK);
  assign w_elig   = w_irq & {4{w_lvl_ok}};

  always_comb begin
    if (w_elig[0])      w_win = 2'd0;
    else if (w_elig[1]) w_win = 2'd1;
    else if (w_elig[2]) w_win = 2'd2;
    else                w_win = 2'd3;
    case (w_win)
      2'd0:    w_win_vec = r_ficv;
      2'd3:    w_win_vec = r_fovv;
      default: w_win_vec = r_focv;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_lvl      <= '0;
      r_vec      <= '0;
      r_ack_src  <= '0;
      r_src      <= '0;
      r_lock_cnt <= 1'b0;
    end else if (CE_R) begin
      r_state    <= w_state_nx;
      r_req      <= w_req_nx;
      r_lvl      <= w_lvl_nx;
      r_vec      <= w_vec_nx;
      r_ack_src  <= w_ack_src_nx;
      r_src      <= w_src_nx;
      r_lock_cnt <= w_lock_cnt_nx;
    end
  end

  // ACK is tested before withdrawal so a simultaneous drop still completes the handshake
  always_comb begin
    w_state_nx    = r_state;
    w_req_nx      = r_req;
    w_lvl_nx      = r_lvl;
    w_vec_nx      = r_vec;
    w_ack_src_nx  = r_ack_src;
    w_src_nx      = r_src;
    w_lock_cnt_nx = r_lock_cnt;
    case (r_state)
      S_IDLE: begin
        w_req_nx = 1'b0;
        if (|w_elig) begin
          w_src_nx   = w_win;
          w_lvl_nx   = r_pri;
          w_vec_nx   = w_win_vec;
          w_req_nx   = 1'b1;
          w_state_nx = S_PEND;
        end
      end
      S_PEND: begin
        if (INT_ACK) begin
          w_req_nx      = 1'b0;
          w_ack_src_nx  = r_src;
          w_lock_cnt_nx = 1'b0;
          w_state_nx    = S_LOCK;
        end else if (!w_elig[r_src]) begin
          w_req_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      S_LOCK: begin
        w_req_nx = 1'b0;
        if (r_lock_cnt) w_state_nx = S_IDLE;
        else            w_lock_cnt_nx = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign INT_REQ = r_req;
  assign INT_LVL = r_lvl;
  assign INT_VEC = r_vec;
  assign ACK_SRC = r_ack_src;

endmodule
